// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one host memory port among NUM_CLIENTS requesters, one
//            whole burst at a time. Round-robin arbitration by default;
//            define MEM_ARBITER_FIXED_PRIO_EN for lowest-index-wins priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int NUM_CLIENTS   = 2,
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64
) (
    input  logic                                   i_clock,
    input  logic                                   i_reset_n,
    input  logic [NUM_CLIENTS-1:0]                 i_c_req_valid,
    output logic [NUM_CLIENTS-1:0]                 o_c_req_ready,
    input  logic [NUM_CLIENTS-1:0]                 i_c_req_opcode,
    input  logic [NUM_CLIENTS*MEM_LEN_BITS-1:0]    i_c_req_len,
    input  logic [NUM_CLIENTS*MEM_ADDR_BITS-1:0]   i_c_req_addr,
    input  logic [NUM_CLIENTS-1:0]                 i_c_wr_valid,
    input  logic [NUM_CLIENTS*MEM_DATA_BITS-1:0]   i_c_wr_bits,
    output logic [NUM_CLIENTS-1:0]                 o_c_rd_valid,
    output logic [MEM_DATA_BITS-1:0]               o_c_rd_bits,
    input  logic [NUM_CLIENTS-1:0]                 i_c_rd_ready,
    output logic                                   o_mem_req_valid,
    output logic                                   o_mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]                o_mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]               o_mem_req_addr,
    output logic                                   o_mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]               o_mem_wr_bits,
    input  logic                                   i_mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]               i_mem_rd_bits,
    output logic                                   o_mem_rd_ready
);

    localparam int                 C_IDX_W    = $clog2(NUM_CLIENTS);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [C_IDX_W-1:0]      r_owner, w_owner_nxt;
    logic [MEM_LEN_BITS-1:0] r_cnt,   w_cnt_nxt;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
    logic [C_IDX_W-1:0]      r_ptr,   w_ptr_nxt;
`endif

    logic [C_IDX_W-1:0]      w_winner;
    logic                    w_found;
    int                      w_idx;
    logic [NUM_CLIENTS-1:0]  w_win_oh, w_own_oh;
    logic                    w_owner_wr_valid, w_owner_rd_ready;

    // Winner search: scan starting at the round-robin pointer (or at 0).
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            w_idx = k;
`else
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_CLIENTS) w_idx = w_idx - NUM_CLIENTS;
`endif
            if (!w_found && i_c_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = C_IDX_W'(w_idx);
            end
        end
    end

    always_comb begin
        o_mem_req_opcode = 1'b0;
        o_mem_req_len    = '0;
        o_mem_req_addr   = '0;
        o_mem_wr_bits    = '0;
        w_owner_wr_valid = 1'b0;
        w_owner_rd_ready = 1'b0;
        w_win_oh         = '0;
        w_own_oh         = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_winner == C_IDX_W'(i)) begin
                w_win_oh[i]      = 1'b1;
                o_mem_req_opcode = i_c_req_opcode[i];
                o_mem_req_len    = i_c_req_len[i*MEM_LEN_BITS +: MEM_LEN_BITS];
                o_mem_req_addr   = i_c_req_addr[i*MEM_ADDR_BITS +: MEM_ADDR_BITS];
            end
            if (r_owner == C_IDX_W'(i)) begin
                w_own_oh[i]      = 1'b1;
                o_mem_wr_bits    = i_c_wr_bits[i*MEM_DATA_BITS +: MEM_DATA_BITS];
                w_owner_wr_valid = i_c_wr_valid[i];
                w_owner_rd_ready = i_c_rd_ready[i];
            end
        end
    end

    assign o_c_rd_bits = i_mem_rd_bits;

    // Handshake outputs are qualified by reset so nothing leaks while it is low.
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_cnt_nxt       = r_cnt;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
        w_ptr_nxt       = r_ptr;
`endif
        o_c_req_ready   = '0;
        o_c_rd_valid    = '0;
        o_mem_req_valid = 1'b0;
        o_mem_wr_valid  = 1'b0;
        o_mem_rd_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    o_c_req_ready   = w_win_oh & {NUM_CLIENTS{i_reset_n}};
                    o_mem_req_valid = i_reset_n;
                    w_owner_nxt     = w_winner;
                    w_cnt_nxt       = o_mem_req_len;
                    w_state_nxt     = o_mem_req_opcode ? S_WRITE : S_READ;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
                    w_ptr_nxt       = (w_winner == C_LAST_IDX) ? '0 : w_winner + 1'b1;
`endif
                end
            end
            S_READ: begin
                o_c_rd_valid   = w_own_oh & {NUM_CLIENTS{i_mem_rd_valid & i_reset_n}};
                o_mem_rd_ready = w_owner_rd_ready & i_reset_n;
                if (i_mem_rd_valid && w_owner_rd_ready) begin
                    if (r_cnt == '0) w_state_nxt = S_IDLE;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_WRITE: begin
                o_mem_wr_valid = w_owner_wr_valid & i_reset_n;
                if (w_owner_wr_valid) begin
                    if (r_cnt == '0) w_state_nxt = S_IDLE;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            r_ptr   <= w_ptr_nxt;
`endif
        end
    end

endmodule

`default_nettype wire
